// File: rtl/ldl_rr_arb_v1.sv
// ---------------------------------------------------------------------------
// ldl_rr_arb_v1
// Round-robin arbiter. It grants one of REQ_NUM requesters and holds that
// grant until the grantee signals done or withdraws its request. The
// round-robin pointer marks the highest-priority index. On each release the
// pointer moves to one past the released grantee. A new winner is picked in
// the same cycle, so back-to-back grants have no idle cycle between them.
//
// Ports
//   clk       in   single clock; all state changes on the rising edge
//   rst       in   synchronous, active-high reset
//   req       in   [REQ_NUM-1:0]   request vector, bit j = requester j
//   done      in   current grantee finishes this cycle (ignored when idle)
//   gnt       out  [REQ_NUM-1:0]   registered one-hot grant, zero when idle
//   gnt_id    out  [BIN_WIDTH-1:0] registered binary grantee index, 0 idle
//   gnt_valid out  registered, equal to |gnt
// ---------------------------------------------------------------------------
module ldl_rr_arb_v1 #(
   parameter int BIN_WIDTH = 2,
   parameter int REQ_NUM   = 1 << BIN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REQ_NUM-1:0]   req,
   input  logic                 done,
   output logic [REQ_NUM-1:0]   gnt,
   output logic [BIN_WIDTH-1:0] gnt_id,
   output logic                 gnt_valid
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t               state_q,     state_d;
   logic [BIN_WIDTH-1:0] ptr_q,       ptr_d;
   logic [REQ_NUM-1:0]   gnt_q,       gnt_d;
   logic [BIN_WIDTH-1:0] gnt_id_q,    gnt_id_d;
   logic                 gnt_valid_q, gnt_valid_d;

   // Two-pass priority pick. The result is {found, index}.
   // Pass 1 finds the lowest set bit at or above the pointer.
   // Pass 2 finds the lowest set bit overall and is used only when pass 1
   // finds nothing. The loops run from the top bit down, so the last hit
   // each loop records is the lowest index.
   function automatic logic [BIN_WIDTH:0] rr_pick(
      input logic [REQ_NUM-1:0]   c,
      input logic [BIN_WIDTH-1:0] p
   );
      logic                 hit_hi;
      logic                 hit_any;
      logic [BIN_WIDTH-1:0] idx_hi;
      logic [BIN_WIDTH-1:0] idx_any;
      hit_hi  = 1'b0;
      hit_any = 1'b0;
      idx_hi  = '0;
      idx_any = '0;
      for (int j = REQ_NUM - 1; j >= 0; j--) begin
         if (c[j]) begin
            hit_any = 1'b1;
            idx_any = BIN_WIDTH'(j);
            if (j >= int'(p)) begin
               hit_hi = 1'b1;
               idx_hi = BIN_WIDTH'(j);
            end
         end
      end
      if (hit_hi) begin
         rr_pick = {1'b1, idx_hi};
      end else begin
         rr_pick = {hit_any, idx_any};
      end
   endfunction

   // Pointer advance modulo REQ_NUM. This also covers REQ_NUM values that
   // are not a power of two.
   function automatic logic [BIN_WIDTH-1:0] ptr_next(
      input logic [BIN_WIDTH-1:0] id
   );
      if (int'(id) == REQ_NUM - 1) begin
         ptr_next = '0;
      end else begin
         ptr_next = id + 1'b1;
      end
   endfunction

   logic [REQ_NUM-1:0]   cand;
   logic [BIN_WIDTH-1:0] pick_ptr;
   logic [BIN_WIDTH:0]   pick;
   logic                 release_now;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      cand        = '0;
      pick_ptr    = ptr_q;
      pick        = '0;
      release_now = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // done has no meaning without a grantee and is ignored here.
            cand     = req;
            pick_ptr = ptr_q;
            pick     = rr_pick(cand, pick_ptr);
            if (pick[BIN_WIDTH]) begin
               state_d                    = ST_GRANT;
               gnt_d                      = '0;
               gnt_d[pick[BIN_WIDTH-1:0]] = 1'b1;
               gnt_id_d                   = pick[BIN_WIDTH-1:0];
               gnt_valid_d                = 1'b1;
            end
         end
         ST_GRANT: begin
            // A release happens on done or when the grantee withdraws. Both
            // in the same cycle count as a single release.
            release_now = done | ~req[gnt_id_q];
            if (release_now) begin
               ptr_d = ptr_next(gnt_id_q);
               // The departing grantee is masked out, so it cannot win back
               // to back even if it still requests.
               cand     = req & ~gnt_q;
               pick_ptr = ptr_d;
               pick     = rr_pick(cand, pick_ptr);
               if (pick[BIN_WIDTH]) begin
                  gnt_d                      = '0;
                  gnt_d[pick[BIN_WIDTH-1:0]] = 1'b1;
                  gnt_id_d                   = pick[BIN_WIDTH-1:0];
                  gnt_valid_d                = 1'b1;
               end else begin
                  state_d     = ST_IDLE;
                  gnt_d       = '0;
                  gnt_id_d    = '0;
                  gnt_valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   // Reset wins over everything. In particular it drops an active grant
   // without advancing the pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;

endmodule
